pc_run_ctrl: RTL and testbench
==============================

Name: pc_run_ctrl

Overview:
- Run-control sequencer for the IF-stage program counter and the pipeline enable, driven by debug-unit commands.
- Supports continuous run and single-step run, pauses on hazard stalls, and drains the pipeline after HALT.
- Reports completion and an executed-cycle count.
- Sits between the debug command decoder and the PC and pipeline-register enables.

Parameters:
- PC_SIZE, 32, width of PC compare bus.
- CYCLE_CNT_SIZE, 32, width of executed-cycle counter.
- DRAIN_CYCLES, 4, enabled cycles after HALT detection needed to retire in-flight instructions (must be ≥1).

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_cmd_run  in  1  one-cycle pulse: start/continue continuous execution.
- i_cmd_step  in  1  one-cycle pulse: start step mode / execute one cycle.
- i_cmd_abort  in  1  one-cycle pulse: return to IDLE from any state.
- i_halt  in  1  HALT decoded in ID stage.
- i_stall  in  1  hazard unit requests PC hold.
- i_pc  in  PC_SIZE  current PC value.
- o_start  out  1  one-cycle pulse to PC start input.
- o_enable  out  1  pipeline/PC enable.
- o_not_load  out  1  PC hold request.
- o_busy  out  1  high in any state except IDLE and END.
- o_done  out  1  high in END.
- o_cycles  out  CYCLE_CNT_SIZE  enabled cycles since last start.
- o_state  out  3  current state encoding, debug visibility.

Behaviour:
- States and encodings: IDLE=0, RUN=1, STEP_ARM=2, STEP_EXEC=3, DRAIN=4, END=5. Codes 6–7 recover to IDLE on the next clock.
- Reset (i_reset=0, asynchronous): state IDLE, drain counter 0, o_cycles 0. All outputs 0.
- Outputs are registered except o_not_load.
- Command priority within a cycle: abort > run > step.
- IDLE:
  - o_enable=0.
  - i_cmd_run → RUN; i_cmd_step → STEP_ARM.
  - On either transition: o_cycles cleared and o_start=1 for exactly the first cycle in the new state.
- RUN:
  - o_enable=1 every cycle; o_cycles +1 per cycle.
  - i_halt → DRAIN, drain counter loaded with DRAIN_CYCLES-1.
  - i_cmd_step → STEP_ARM (pause).
  - i_halt and i_stall in the same cycle: halt wins.
- STEP_ARM:
  - o_enable=0.
  - i_cmd_step → STEP_EXEC.
  - i_cmd_run → RUN (resume continuous).
- STEP_EXEC:
  - o_enable=1 for exactly one cycle; o_cycles +1.
  - Next state: DRAIN if i_halt, else STEP_ARM.
- DRAIN:
  - o_enable=1; o_cycles +1 per cycle; counter decrements.
  - At counter=0 → END. Total enabled DRAIN cycles = DRAIN_CYCLES.
  - Commands other than abort are ignored.
- END:
  - o_enable=0, o_done=1; o_cycles holds.
  - Only i_cmd_abort leaves, → IDLE; o_cycles retained until the next start.
- o_not_load = i_stall & (state==RUN | state==STEP_EXEC). It is combinational and forced 0 elsewhere. A stalled cycle still counts in o_cycles.
- o_cycles saturates at all-ones; it does not wrap.
- i_cmd_abort in any state → IDLE next cycle, with o_enable=0 that cycle.

Optional Feature:
- Macro: PC_RUN_CTRL_BREAKPOINT_EN.
- With the macro defined:
  - Extra ports i_bp_addr (in, PC_SIZE), i_bp_valid (in, 1), o_bp_hit (out, 1).
  - In RUN with i_bp_valid=1 and i_pc==i_bp_addr (and no i_halt): next state STEP_ARM; o_bp_hit pulses one cycle.
  - Halt has priority over breakpoint.
  - Resuming via run from the same PC does not re-trigger until i_pc changes.
- Without the macro: these ports are absent and RUN never pauses on PC match.

Decomposition:
- Shared header pc_run_ctrl.vh holds:
  - state encodings and BITS_FOR_STATE_PC_RUN_CTRL (3);
  - DEFAULT_CYCLE_CNT_SIZE and DEFAULT_DRAIN_CYCLES;
  - reuse of DEFAULT_PC_SIZE and CLEAR from pc.vh.
- One natural sub-module: pc_run_ctrl_sat_counter (clear, increment-enable, saturating, parameterised width), instantiated for o_cycles.

Test Plan:
1. Reset held low 3 cycles, then released → all outputs 0, o_state=0. Assert reset while in RUN → o_enable falls immediately (async) and o_cycles=0.
2. Run then HALT: i_cmd_run pulse, then i_halt at enabled cycle 10 → o_start one pulse; o_enable high 10 RUN + 4 DRAIN cycles; o_done=1; o_cycles=14.
3. Three steps: i_cmd_step ×4 pulses, spaced 5 cycles → one arm, then exactly three single-cycle o_enable pulses; o_cycles=3; o_state returns to 2 between steps.
4. Stall during RUN: i_stall high 2 cycles → o_not_load high those 2 cycles; o_enable stays 1; counting continues. i_stall in STEP_ARM → o_not_load=0.
5. Simultaneous events: i_cmd_run+i_cmd_abort in RUN → IDLE. i_cmd_run+i_cmd_step in IDLE → RUN. i_cmd_run in DRAIN → ignored; END is still reached after 4 cycles.
6. CYCLE_CNT_SIZE=4, run 20 cycles → o_cycles saturates at 15. With PC_RUN_CTRL_BREAKPOINT_EN and i_bp_addr=0x10 → pause at i_pc=0x10, o_bp_hit one pulse.

Source files
------------

// File: rtl/pc_run_ctrl_pkg.sv
// pc_run_ctrl_pkg: state encodings, default sizes and helpers shared by the run-control sequencer.
package pc_run_ctrl_pkg;
    localparam int BITS_FOR_STATE_PC_RUN_CTRL = 3;
    localparam int DEFAULT_PC_SIZE = 32;
    localparam int DEFAULT_CYCLE_CNT_SIZE = 32;
    localparam int DEFAULT_DRAIN_CYCLES = 4;
    localparam logic CLEAR = 1'b0;

    typedef enum logic [BITS_FOR_STATE_PC_RUN_CTRL-1:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STEP_ARM  = 3'd2,
        STEP_EXEC = 3'd3,
        DRAIN     = 3'd4,
        END       = 3'd5
    } state_t;

    function automatic logic is_enabled(input state_t s);
        return s == RUN || s == STEP_EXEC || s == DRAIN;
    endfunction
endpackage

// File: rtl/pc_run_ctrl_sat_counter.sv
// pc_run_ctrl_sat_counter: clearable up-counter that sticks at all-ones instead of wrapping.
module pc_run_ctrl_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != '1) count <= count + WIDTH'(1);
    end
endmodule

// File: rtl/pc_run_ctrl.sv
// pc_run_ctrl: debug run/step sequencer driving PC start, pipeline enable and PC hold.
// Define PC_RUN_CTRL_BREAKPOINT_EN to add a PC breakpoint that pauses continuous run.
module pc_run_ctrl
    import pc_run_ctrl_pkg::*;
#(
    parameter int PC_SIZE        = DEFAULT_PC_SIZE,
    parameter int CYCLE_CNT_SIZE = DEFAULT_CYCLE_CNT_SIZE,
    parameter int DRAIN_CYCLES   = DEFAULT_DRAIN_CYCLES
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_cmd_run,
    input  logic                      i_cmd_step,
    input  logic                      i_cmd_abort,
    input  logic                      i_halt,
    input  logic                      i_stall,
    input  logic [PC_SIZE-1:0]        i_pc,
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
    input  logic [PC_SIZE-1:0]        i_bp_addr,
    input  logic                      i_bp_valid,
    output logic                      o_bp_hit,
`endif
    output logic                      o_start,
    output logic                      o_enable,
    output logic                      o_not_load,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [CYCLE_CNT_SIZE-1:0] o_cycles,
    output logic [BITS_FOR_STATE_PC_RUN_CTRL-1:0] o_state
);
    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;

    state_t state, nxt;
    logic [DW-1:0] drain_cnt;
    logic bp_match;

`ifdef PC_RUN_CTRL_BREAKPOINT_EN
    logic bp_take, bp_block;
    logic [PC_SIZE-1:0] bp_pc;
    // A hit is masked while the PC still sits on the address that last fired.
    assign bp_match = i_bp_valid && i_pc == i_bp_addr && !(bp_block && i_pc == bp_pc);
    assign bp_take  = state == RUN && bp_match && !i_halt && !i_cmd_abort;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bp_block <= CLEAR;
            bp_pc    <= '0;
            o_bp_hit <= CLEAR;
        end else begin
            o_bp_hit <= bp_take;
            if (bp_take) begin
                bp_block <= 1'b1;
                bp_pc    <= i_pc;
            end else if (i_pc != bp_pc) bp_block <= 1'b0;
        end
    end
`else
    logic unused_pc;
    assign bp_match  = 1'b0;
    assign unused_pc = ^i_pc;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = i_cmd_run ? RUN : i_cmd_step ? STEP_ARM : IDLE;
            RUN:       nxt = i_halt ? DRAIN : bp_match ? STEP_ARM : i_cmd_run ? RUN : i_cmd_step ? STEP_ARM : RUN;
            STEP_ARM:  nxt = i_cmd_run ? RUN : i_cmd_step ? STEP_EXEC : STEP_ARM;
            STEP_EXEC: nxt = i_halt ? DRAIN : STEP_ARM;
            DRAIN:     nxt = drain_cnt == '0 ? END : DRAIN;
            END:       nxt = END;
            default:   nxt = IDLE;
        endcase
        if (i_cmd_abort) nxt = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            o_start   <= CLEAR;
            o_enable  <= CLEAR;
            o_busy    <= CLEAR;
            o_done    <= CLEAR;
        end else begin
            state     <= nxt;
            drain_cnt <= (nxt == DRAIN && state != DRAIN) ? DW'(DRAIN_CYCLES - 1) :
                         (state == DRAIN && drain_cnt != '0) ? drain_cnt - DW'(1) : drain_cnt;
            o_start   <= state == IDLE && nxt != IDLE;
            o_enable  <= is_enabled(nxt);
            o_busy    <= nxt != IDLE && nxt != END;
            o_done    <= nxt == END;
        end
    end

    pc_run_ctrl_sat_counter #(.WIDTH(CYCLE_CNT_SIZE)) u_cycles (
        .clk   (i_clk),
        .rst_n (i_reset),
        .clr   (state == IDLE && nxt != IDLE),
        .inc   (is_enabled(state)),
        .count (o_cycles)
    );

    assign o_not_load = i_stall && (state == RUN || state == STEP_EXEC);
    assign o_state    = state;
endmodule

// File: tb/tb_pc_run_ctrl.sv
// tb_pc_run_ctrl: directed plus random stimulus checked against a cycle-level behavioural model.
module tb_pc_run_ctrl;
    localparam int PW   = 32;
    localparam int CW   = 4;
    localparam int DC   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int S_IDLE = 0, S_RUN = 1, S_ARM = 2, S_EXEC = 3, S_DRAIN = 4, S_END = 5;

    logic clk = 1'b0, rst_n = 1'b0;
    logic run = 1'b0, step = 1'b0, abort = 1'b0, halt = 1'b0, stall = 1'b0;
    logic [PW-1:0] pc = '0;
    logic o_start, o_enable, o_not_load, o_busy, o_done;
    logic [CW-1:0] o_cycles;
    logic [2:0] o_state;
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
    logic [PW-1:0] bp_addr = 32'h10;
    logic bp_valid = 1'b0;
    logic o_bp_hit;
    bit m_hit, blk;
    logic [PW-1:0] blk_pc;
`endif

    int n_chk = 0, n_err = 0;
    int ms, left, mc;
    bit m_en, m_st, m_bz, m_dn;

    always #5 clk = ~clk;

    pc_run_ctrl #(.PC_SIZE(PW), .CYCLE_CNT_SIZE(CW), .DRAIN_CYCLES(DC)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_cmd_run(run), .i_cmd_step(step), .i_cmd_abort(abort),
        .i_halt(halt), .i_stall(stall), .i_pc(pc),
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
        .i_bp_addr(bp_addr), .i_bp_valid(bp_valid), .o_bp_hit(o_bp_hit),
`endif
        .o_start(o_start), .o_enable(o_enable), .o_not_load(o_not_load), .o_busy(o_busy),
        .o_done(o_done), .o_cycles(o_cycles), .o_state(o_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ms = S_IDLE; left = 0; mc = 0;
        m_en = 0; m_st = 0; m_bz = 0; m_dn = 0;
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
        m_hit = 0; blk = 0; blk_pc = '0;
`endif
    endtask

    // One clock of the debug sequencer as described by its command rules.
    task automatic model_step(input bit r, input bit s, input bit a, input bit h, input logic [PW-1:0] p);
        int nx;
        bit bp;
        bp = 0;
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
        bp = bp_valid && p == bp_addr && !(blk && p == blk_pc);
`endif
        nx = ms;
        if (a) nx = S_IDLE;
        else if (ms == S_IDLE) nx = r ? S_RUN : s ? S_ARM : S_IDLE;
        else if (ms == S_RUN) begin
            if (h) nx = S_DRAIN;
            else if (bp) nx = S_ARM;
            else if (!r && s) nx = S_ARM;
        end
        else if (ms == S_ARM) nx = r ? S_RUN : s ? S_EXEC : S_ARM;
        else if (ms == S_EXEC) nx = h ? S_DRAIN : S_ARM;
        else if (ms == S_DRAIN) begin
            left--;
            if (left == 0) nx = S_END;
        end
        if (nx == S_DRAIN && ms != S_DRAIN) left = DC;
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
        m_hit = ms == S_RUN && !a && !h && bp;
        if (m_hit) begin blk = 1; blk_pc = p; end
        else if (p != blk_pc) blk = 0;
`endif
        if (ms == S_RUN || ms == S_EXEC || ms == S_DRAIN) mc = mc == CMAX ? CMAX : mc + 1;
        if (ms == S_IDLE && nx != S_IDLE) mc = 0;
        m_en = nx == S_RUN || nx == S_EXEC || nx == S_DRAIN;
        m_st = ms == S_IDLE && nx != S_IDLE;
        m_bz = nx != S_IDLE && nx != S_END;
        m_dn = nx == S_END;
        ms = nx;
    endtask

    task automatic cyc(input bit r, input bit s, input bit a, input bit h, input bit t, input logic [PW-1:0] p);
        @(negedge clk);
        run = r; step = s; abort = a; halt = h; stall = t; pc = p;
        #1;
        check("not_load", o_not_load, t && (ms == S_RUN || ms == S_EXEC));
        model_step(r, s, a, h, p);
        @(posedge clk);
        #1;
        check("state", o_state, ms);
        check("enable", o_enable, m_en);
        check("start", o_start, m_st);
        check("busy", o_busy, m_bz);
        check("done", o_done, m_dn);
        check("cycles", o_cycles, mc);
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
        check("bp_hit", o_bp_hit, m_hit);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, pc);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", o_state, 0);
        check("rst_enable", o_enable, 0);
        check("rst_start", o_start, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_cycles", o_cycles, 0);
        rst_n = 1'b1;
        idle(2);
        // async reset while running
        cyc(1, 0, 0, 0, 0, pc);
        idle(5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_enable", o_enable, 0);
        check("async_cycles", o_cycles, 0);
        check("async_state", o_state, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        // run, halt on enabled cycle 10, drain 4
        cyc(1, 0, 0, 0, 0, pc);
        idle(9);
        cyc(0, 0, 0, 1, 0, pc);
        idle(4);
        check("t2_cycles", o_cycles, 14);
        check("t2_done", o_done, 1);
        cyc(0, 0, 1, 0, 0, pc);
        // arm then three single steps
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 0, pc);
            idle(4);
        end
        check("t3_cycles", o_cycles, 3);
        check("t3_state", o_state, S_ARM);
        cyc(0, 0, 0, 0, 1, pc);
        // stall during run, then stall while armed
        cyc(1, 0, 0, 0, 0, pc);
        cyc(0, 0, 0, 0, 1, pc);
        cyc(0, 0, 0, 0, 1, pc);
        cyc(0, 1, 0, 0, 0, pc);
        cyc(0, 0, 0, 0, 1, pc);
        // simultaneous commands
        cyc(1, 0, 0, 0, 0, pc);
        cyc(1, 0, 1, 0, 0, pc);
        check("t5_abort", o_state, S_IDLE);
        cyc(1, 1, 0, 0, 0, pc);
        check("t5_runwins", o_state, S_RUN);
        cyc(0, 0, 0, 1, 0, pc);
        cyc(1, 0, 0, 0, 0, pc);
        idle(3);
        check("t5_end", o_state, S_END);
        // saturation
        cyc(0, 0, 1, 0, 0, pc);
        cyc(1, 0, 0, 0, 0, pc);
        idle(20);
        check("t6_sat", o_cycles, CMAX);
        cyc(0, 0, 1, 0, 0, pc);
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
        bp_valid = 1'b1;
        cyc(1, 0, 0, 0, 0, 32'h0c);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 32'h0d + i);
        cyc(1, 0, 0, 0, 0, 32'h10);
        cyc(0, 0, 0, 0, 0, 32'h10);
        cyc(0, 0, 1, 0, 0, 32'h0);
`endif
        for (int i = 0; i < 2000; i++) begin
`ifdef PC_RUN_CTRL_BREAKPOINT_EN
            bp_valid = $urandom_range(99) < 50;
`endif
            cyc($urandom_range(99) < 6, $urandom_range(99) < 8, $urandom_range(99) < 2,
                $urandom_range(99) < 4, $urandom_range(99) < 30, PW'($urandom_range(31)));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
